// File: rtl/prog_sequencer.sv
// prog_sequencer: fetches instructions (plus an immediate for mvi) from program memory and hands them to a processor
module prog_sequencer #(
    parameter int ADDR_W = 8,
    parameter int WD_MAX = 15
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic              stop,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [15:0]       mem_rdata,
    output logic [15:0]       cpu_din,
    output logic              cpu_run,
    input  logic              cpu_done,
    output logic              busy,
    output logic              halted,
    output logic              error,
    output logic [ADDR_W-1:0] pc,
    output logic [15:0]       instr_count
);
    localparam int WD_W = $clog2(WD_MAX + 1);

    typedef enum logic [2:0] {IDLE, FETCH_I, LOAD_I, FETCH_D, LOAD_D, ISSUE, EXEC, HALT} state_t;

    state_t          state, state_n;
    logic [15:0]     instr_reg, imm_reg;
    logic [WD_W-1:0] wd;
    logic            stop_q, is_mvi, idle_like, stop_req, wd_expire;

    assign is_mvi    = instr_reg[8:6] == 3'b001;
    assign idle_like = state == IDLE || state == HALT;
    assign stop_req  = stop || stop_q;
    // last permitted EXEC cycle: a missing cpu_done here ends in HALT
    assign wd_expire = wd == WD_W'(WD_MAX - 1);
    assign mem_addr  = pc;

    // state register
    always_ff @(posedge clock) begin
        state <= reset ? IDLE : state_n;
    end

    // next-state selection
    always_comb begin
        state_n = state;
        case (state)
            IDLE, HALT: state_n = start ? FETCH_I : state;
            FETCH_I:    state_n = LOAD_I;
            LOAD_I:     state_n = mem_rdata[15:9] == 7'h7F ? HALT :
                                  mem_rdata[8:6] == 3'b001 ? FETCH_D : ISSUE;
            FETCH_D:    state_n = LOAD_D;
            LOAD_D:     state_n = ISSUE;
            ISSUE:      state_n = EXEC;
            EXEC:       state_n = cpu_done ? (stop_req ? IDLE : FETCH_I) :
                                  wd_expire ? HALT : EXEC;
            default:    state_n = IDLE;
        endcase
    end

    // state-decoded outputs, forced quiet while reset is asserted
    always_comb begin
        mem_rd  = 1'b0;
        cpu_run = 1'b0;
        cpu_din = 16'h0000;
        busy    = !reset && !idle_like;
        halted  = !reset && state == HALT;
        if (!reset) begin
            mem_rd  = state == FETCH_I || state == FETCH_D;
            cpu_run = state == ISSUE;
            cpu_din = state == ISSUE ? instr_reg :
                      state == EXEC  ? (is_mvi ? imm_reg : instr_reg) : 16'h0000;
        end
    end

    // program counter, instruction/immediate latches, counters and stop latch
    always_ff @(posedge clock) begin
        if (reset) begin
            pc          <= '0;
            instr_reg   <= 16'h0000;
            imm_reg     <= 16'h0000;
            instr_count <= 16'h0000;
            error       <= 1'b0;
            stop_q      <= 1'b0;
            wd          <= '0;
        end else begin
            case (state)
                IDLE, HALT: if (start) begin
                    pc          <= start_addr;
                    error       <= 1'b0;
                    instr_count <= 16'h0000;
                end
                LOAD_I: begin
                    instr_reg <= mem_rdata;
                    pc        <= pc + 1'b1;
                end
                LOAD_D: begin
                    imm_reg <= mem_rdata;
                    pc      <= pc + 1'b1;
                end
                ISSUE: wd <= '0;
                EXEC: begin
                    if (cpu_done)
                        instr_count <= instr_count == 16'hFFFF ? instr_count : instr_count + 16'd1;
                    else if (wd_expire)
                        error <= 1'b1;
                    else
                        wd <= wd + 1'b1;
                end
                default: ;
            endcase
            stop_q <= (state_n == IDLE || state_n == HALT) ? 1'b0 : (!idle_like && stop_req);
        end
    end
endmodule
